// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command FIFO, operand issue and result capture around a combinational ALU (optional ALU_STICKY_FLAGS_EN)
`timescale 1ns/1ps
module alu_op_sequencer #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [OPW-1:0]           in_opcode,
    input  logic                     in_cin,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [OPW-1:0]           alu_opcode,
    output logic                     alu_cin,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic [3:0]               alu_flags,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [3:0]               out_flags,
    output logic [OPW-1:0]           out_opcode,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef ALU_STICKY_FLAGS_EN
    ,
    output logic [3:0]               sticky_flags,
    input  logic                     sticky_clr
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mem_a   [DEPTH];
    logic [WIDTH-1:0]  mem_b   [DEPTH];
    logic [OPW-1:0]    mem_op  [DEPTH];
    logic              mem_cin [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [WIDTH-1:0]  alu_a_q, alu_b_q, out_result_q;
    logic [OPW-1:0]    alu_opcode_q, out_opcode_q;
    logic              alu_cin_q, out_valid_q;
    logic [3:0]        out_flags_q;
    logic              push, pop, capture, release_out;

    // in_ready depends only on the registered count, so a same-cycle pop never lets a full FIFO accept
    assign in_ready   = (count_q != CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_cin    = alu_cin_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;
    assign out_opcode = out_opcode_q;

    // Issue/capture sequencing: pop into the operand registers, give the ALU one cycle, then hold the result
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                capture = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    release_out = 1'b1;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage; contents are meaningless until the pointers/count say otherwise, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr_q]   <= in_a;
            mem_b[wr_ptr_q]   <= in_b;
            mem_op[wr_ptr_q]  <= in_opcode;
            mem_cin[wr_ptr_q] <= in_cin;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // State register, operand registers (held between ops) and the result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
            alu_cin_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
            out_opcode_q <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                alu_a_q      <= mem_a[rd_ptr_q];
                alu_b_q      <= mem_b[rd_ptr_q];
                alu_opcode_q <= mem_op[rd_ptr_q];
                alu_cin_q    <= mem_cin[rd_ptr_q];
            end
            if (capture) begin
                out_valid_q  <= 1'b1;
                out_result_q <= alu_result;
                out_flags_q  <= alu_flags;
                out_opcode_q <= alu_opcode_q;
            end else if (release_out) begin
                out_valid_q  <= 1'b0;
            end
        end
    end

`ifdef ALU_STICKY_FLAGS_EN
    logic [3:0] sticky_q;
    assign sticky_flags = sticky_q;

    // Accumulate flags across captures; an explicit clear wins over a same-cycle capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= '0;
        end else if (sticky_clr) begin
            sticky_q <= '0;
        end else if (capture) begin
            sticky_q <= sticky_q | alu_flags;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer with a behavioural shift ALU
`timescale 1ns/1ps
module tb_alu_op_sequencer;

    localparam int WIDTH = 32;
    localparam int OPW   = 5;
    localparam int DEPTH = 4;
    localparam logic [4:0] SHL = 5'b01000;
    localparam logic [4:0] SHR = 5'b01001;
    localparam logic [4:0] SAR = 5'b01010;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready;
    logic [WIDTH-1:0]  in_a, in_b;
    logic [OPW-1:0]    in_opcode;
    logic              in_cin;
    logic [WIDTH-1:0]  alu_a, alu_b, alu_result;
    logic [OPW-1:0]    alu_opcode;
    logic              alu_cin;
    logic [3:0]        alu_flags;
    logic              out_valid, out_ready;
    logic [WIDTH-1:0]  out_result;
    logic [3:0]        out_flags;
    logic [OPW-1:0]    out_opcode;
    logic              busy;
    logic [2:0]        fifo_count;
`ifdef ALU_STICKY_FLAGS_EN
    logic [3:0]        sticky_flags;
    logic              sticky_clr;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int max_cnt = 0;
    logic [40:0] got_q[$];
    int          got_cyc[$];
    logic [40:0] exp_q[$];

    alu_op_sequencer #(.WIDTH(WIDTH), .OPW(OPW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode), .in_cin(in_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags), .out_opcode(out_opcode),
        .busy(busy), .fifo_count(fifo_count)
`ifdef ALU_STICKY_FLAGS_EN
        , .sticky_flags(sticky_flags), .sticky_clr(sticky_clr)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: returns {V,C,N,Z, result}
    function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] op, input logic cin);
        logic [32:0] t;
        logic [31:0] r;
        logic        c;
        int unsigned n;
        n = b[4:0];
        case (op)
            5'b01000: begin t = {1'b0, a} << n;            r = t[31:0]; c = t[32]; end
            5'b01001: begin t = {a, 1'b0} >> n;            r = t[32:1]; c = t[0];  end
            5'b01010: begin t = $signed({a, 1'b0}) >>> n;  r = t[32:1]; c = t[0];  end
            default:  begin t = {1'b0, a} + {1'b0, b} + {32'd0, cin}; r = t[31:0]; c = t[32]; end
        endcase
        return {1'b0, c, r[31], (r == 32'd0), r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_fn(alu_a, alu_b, alu_opcode, alu_cin);

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_q.push_back({out_flags, out_opcode, out_result});
            got_cyc.push_back(cyc);
        end
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drain(input int n, input int limit);
        for (int i = 0; i < limit && got_q.size() < n; i++) tick;
    endtask

    initial begin
        logic [35:0] r;
        logic        accepted;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_opcode = '0; in_cin = 1'b0; out_ready = 1'b0;
`ifdef ALU_STICKY_FLAGS_EN
        sticky_clr = 1'b0;
`endif
        repeat (2) tick;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_flags", out_flags, 0);
        chk("rst_out_opcode", out_opcode, 0);
        rst = 1'b0;
        tick;

        // single op: SHL 5 by 1
        got_q.delete(); got_cyc.delete();
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 32'd5; in_b = 32'd1; in_opcode = SHL; in_cin = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("single_count_after_push", fifo_count, 1);
        chk("single_busy", busy, 1);
        chk("single_no_early_valid", out_valid, 0);
        tick;
        chk("single_alu_a", alu_a, 5);
        chk("single_alu_b", alu_b, 1);
        chk("single_alu_opcode", alu_opcode, SHL);
        chk("single_alu_cin", alu_cin, 1);
        chk("single_count_after_pop", fifo_count, 0);
        chk("single_valid_at_e1", out_valid, 0);
        tick;
        chk("single_out_valid", out_valid, 1);
        chk("single_out_result", out_result, 10);
        chk("single_out_flags", out_flags, 4'b0000);
        chk("single_out_opcode", out_opcode, SHL);
        tick;
        chk("single_consumed", out_valid, 0);
        chk("single_idle", busy, 0);
        chk("single_alu_a_held", alu_a, 5);
        chk("single_one_result", got_q.size(), 1);
        in_cin = 1'b0;

        // ordered burst
        got_q.delete(); got_cyc.delete();
        in_valid = 1'b1; in_b = 32'd1;
        in_a = 32'h8000_0000; in_opcode = SHL; tick;
        in_a = 32'h8000_0000; in_opcode = SHR; tick;
        in_a = 32'hFFFF_FFF8; in_opcode = SAR; tick;
        in_valid = 1'b0;
        drain(3, 30);
        chk("burst_count", got_q.size(), 3);
        if (got_q.size() >= 3) begin
            chk("burst_r0", got_q[0], {4'b0101, SHL, 32'h0000_0000});
            chk("burst_r1", got_q[1], {4'b0000, SHR, 32'h4000_0000});
            chk("burst_r2", got_q[2], {4'b0010, SAR, 32'hFFFF_FFFC});
            chk("burst_gap01", got_cyc[1] - got_cyc[0], 2);
            chk("burst_gap12", got_cyc[2] - got_cyc[1], 2);
        end
        repeat (3) tick;
        chk("burst_idle", busy, 0);

        // back-pressure and full FIFO
        got_q.delete(); got_cyc.delete();
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            in_valid = 1'b1; in_a = 32'(k + 1); in_b = 32'd1; in_opcode = SHL;
            tick;
        end
        in_valid = 1'b0;
        chk("full_count", fifo_count, DEPTH);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        chk("full_out_result", out_result, 2);
        chk("full_busy", busy, 1);
        repeat (3) tick;
        chk("held_out_result", out_result, 2);
        chk("held_out_valid", out_valid, 1);
        chk("held_count", fifo_count, DEPTH);
        out_ready = 1'b1;
        drain(DEPTH + 1, 40);
        repeat (6) tick;
        chk("full_drain_count", got_q.size(), DEPTH + 1);
        for (int k = 0; k < DEPTH + 1 && k < got_q.size(); k++)
            chk($sformatf("full_drain_r%0d", k), got_q[k][31:0], 2 * (k + 1));

        // wrap-around with random back-pressure
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        max_cnt = 0;
        for (int n = 0; n < 3 * DEPTH; n++) begin
            in_valid = 1'b1;
            in_a = $urandom;
            in_b = 32'($urandom_range(0, 31));
            case ($urandom_range(0, 2))
                0: in_opcode = SHL;
                1: in_opcode = SHR;
                default: in_opcode = SAR;
            endcase
            accepted = 1'b0;
            for (int g = 0; g < 50 && !accepted; g++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (in_ready) begin
                    accepted = 1'b1;
                    r = alu_fn(in_a, in_b, in_opcode, in_cin);
                    exp_q.push_back({r[35:32], in_opcode, r[31:0]});
                end
                tick;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain(3 * DEPTH, 100);
        chk("wrap_count", got_q.size(), 3 * DEPTH);
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            chk($sformatf("wrap_r%0d", k), got_q[k], exp_q[k]);
        chk("wrap_max_count", (max_cnt <= DEPTH), 1);
        repeat (3) tick;

        // asynchronous reset mid-EXEC with 3 queued
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_a = 32'(k + 1); in_b = 32'd1; in_opcode = SHL;
            tick;
        end
        out_ready = 1'b1; in_a = 32'd9;
        tick;
        in_valid = 1'b0;
        chk("pre_rst_count", fifo_count, 3);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        tick;
        rst = 1'b0;
        got_q.delete(); got_cyc.delete();
        repeat (8) tick;
        chk("post_rst_nothing", got_q.size(), 0);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_busy", busy, 0);

`ifdef ALU_STICKY_FLAGS_EN
        chk("sticky_reset", sticky_flags, 0);
        got_q.delete(); got_cyc.delete();
        out_ready = 1'b1;
        in_valid = 1'b1; in_b = 32'd1; in_opcode = SHL;
        in_a = 32'h8000_0000; tick;
        in_a = 32'd5; tick;
        in_valid = 1'b0;
        drain(2, 30);
        tick;
        chk("sticky_accum", sticky_flags, 4'b0101);
        sticky_clr = 1'b1;
        tick;
        sticky_clr = 1'b0;
        chk("sticky_cleared", sticky_flags, 4'b0000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
